// File: rtl/fun_driver.sv
`default_nettype none
// ============================================================================
//  Module   : fun_driver
//  Purpose  : Upstream sequencer for the fun datapath (y = sqrt(a + cbrt(b))).
//             Accepts operand pairs on a valid/ready stream. Launches one fun
//             operation at a time and holds the operands stable while it runs.
//             Captures the result when fun's busy falls, buffers results in a
//             small FIFO and returns them on a valid/ready stream.
//  Ports    : clk_i, rst_i (async, active-low)
//             in_valid_i / in_ready_o / in_a_bi / in_b_bi  : operand stream
//             fun_start_o / fun_a_bo / fun_b_bo            : launch to fun
//             fun_busy_i / fun_y_bi                        : status from fun
//             out_valid_o / out_ready_i / out_y_bo         : result stream
//             level_o : FIFO occupancy, busy_o : op in flight,
//             err_o   : sticky launch timeout
//  Revision : 1.0  initial release
// ============================================================================
module fun_driver #(
   parameter int W       = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [W-1:0]               in_a_bi,
   input  logic [W-1:0]               in_b_bi,
   output logic                       fun_start_o,
   output logic [W-1:0]               fun_a_bo,
   output logic [W-1:0]               fun_b_bo,
   input  logic                       fun_busy_i,
   input  logic [W-1:0]               fun_y_bi,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [W-1:0]               out_y_bo,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       busy_o,
   output logic                       err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;

   logic [W-1:0]    mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [LW-1:0]   level_q;

   logic            push;
   logic            pop;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Operands are only ever loaded here, so they stay frozen for
            // the whole launch.
            if (in_valid_i && in_ready_o) begin
               a_d     = in_a_bi;
               b_d     = in_b_bi;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (fun_busy_i) begin
               state_d = S_WAIT_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               // Counter is about to reach TIMEOUT: fun never acknowledged
               // the start, give up without producing a result.
               if (cnt_q == CW'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_DONE: begin
            if (!fun_busy_i) begin
               push    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A free slot is required before accepting, so a push can never land on
   // a full FIFO: while an op is in flight only pops can happen.
   assign in_ready_o  = (state_q == S_IDLE) && (level_q < LW'(DEPTH));
   assign fun_start_o = (state_q == S_START);
   assign fun_a_bo    = a_q;
   assign fun_b_bo    = b_q;
   assign busy_o      = (state_q != S_IDLE);
   assign err_o       = err_q;

   // ---------------------------------------------------------------- FIFO
   assign out_valid_o = (level_q != '0);
   assign pop         = out_valid_o && out_ready_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         // Pointers are AW bits wide, so they wrap mod DEPTH for free.
         if (push) begin
            mem_q[wr_ptr_q] <= fun_y_bi;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   assign out_y_bo = out_valid_o ? mem_q[rd_ptr_q] : '0;
   assign level_o  = level_q;

endmodule
`default_nettype wire
